// File: rtl/hls_infer_ctrl.sv
// hls_infer_ctrl: control wrapper around an hls4ml inference core using the
// ap_ctrl_hs protocol with ap_vld ports. Turns a valid/ready stream of feature
// vectors into start/done transactions on the core and returns each result
// (or a timeout/missing-result error) on a valid/ready output stream.
//
// Optional feature macro: HLS_INFER_INBUF_EN
//   defined   -> one-entry input buffer; a vector can be accepted while the
//                core is busy and is started straight from the OUT handshake.
//   undefined -> no buffer; in_ready is high only in IDLE.
//
// Handshake rule (both streams): a transfer happens on a rising clk edge where
// valid and ready are both 1. The valid side keeps its data stable until that
// edge; the ready side may change freely. out_valid never drops without a
// transfer, including after a timeout.
module hls_infer_ctrl #(
  parameter int N_IN    = 3,
  parameter int IN_W    = 16,
  parameter int N_OUT   = 1,
  parameter int OUT_W   = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*OUT_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_err,
  output logic                   core_start,
  output logic [N_IN*IN_W-1:0]   core_in,
  output logic                   core_in_vld,
  input  logic                   core_ready,
  input  logic                   core_done,
  input  logic [N_OUT*OUT_W-1:0] core_out,
  input  logic                   core_out_vld,
  output logic [CNT_W-1:0]       infer_count,
  output logic [7:0]             timeout_cnt,
  output logic [1:0]             dbg_state
);

  localparam int IN_BITS  = N_IN * IN_W;
  localparam int OUT_BITS = N_OUT * OUT_W;
  localparam int TO_W     = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  core_start_q, core_start_d;
  logic                  core_in_vld_q, core_in_vld_d;
  logic [IN_BITS-1:0]    core_in_q, core_in_d;
  logic [OUT_BITS-1:0]   out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_err_q, out_err_d;
  logic                  got_vld_q, got_vld_d;
  logic [TO_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]      infer_count_q, infer_count_d;
  logic [7:0]            timeout_cnt_q, timeout_cnt_d;
`ifdef HLS_INFER_INBUF_EN
  logic                  buf_full_q, buf_full_d;
  logic [IN_BITS-1:0]    buf_data_q, buf_data_d;
`endif

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    core_start_d  = core_start_q;
    core_in_vld_d = core_in_vld_q;
    core_in_d     = core_in_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_err_d     = out_err_q;
    got_vld_d     = got_vld_q;
    wait_cnt_d    = wait_cnt_q;
    infer_count_d = infer_count_q;
    timeout_cnt_d = timeout_cnt_q;
`ifdef HLS_INFER_INBUF_EN
    buf_full_d    = buf_full_q;
    buf_data_d    = buf_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        // The buffer is bypassed here: an accepted vector goes straight to the core.
        if (in_fire) begin
          core_in_d     = in_data;
          core_start_d  = 1'b1;
          core_in_vld_d = 1'b1;
          state_d       = S_START;
        end
      end

      S_START: begin
        if (core_ready) begin
          core_start_d  = 1'b0;
          core_in_vld_d = 1'b0;
          wait_cnt_d    = '0;
          if (core_out_vld) begin
            out_data_d = core_out;
            got_vld_d  = 1'b1;
          end
          // A zero-latency core may finish in the very cycle it accepts.
          if (core_done) begin
            out_valid_d = 1'b1;
            out_err_d   = ~(got_vld_q | core_out_vld);
            state_d     = S_OUT;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // Capture happens before the done check so vld+done together is not an error.
        if (core_out_vld) begin
          out_data_d = core_out;
          got_vld_d  = 1'b1;
        end
        if (core_done) begin
          out_valid_d = 1'b1;
          out_err_d   = ~(got_vld_q | core_out_vld);
          state_d     = S_OUT;
        end else if (wait_cnt_q == TO_LAST) begin
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_data_d  = '0;
          if (timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        // Result is held until taken; a late core_done here is simply ignored.
        if (out_fire) begin
          out_valid_d   = 1'b0;
          out_err_d     = 1'b0;
          out_data_d    = '0;
          got_vld_d     = 1'b0;
          infer_count_d = infer_count_q + CNT_W'(1);
          state_d       = S_IDLE;
`ifdef HLS_INFER_INBUF_EN
          if (buf_full_q) begin
            core_in_d     = buf_data_q;
            buf_full_d    = 1'b0;
            core_start_d  = 1'b1;
            core_in_vld_d = 1'b1;
            state_d       = S_START;
          end else if (in_fire) begin
            // Vector arriving on the same edge goes directly to the core.
            core_in_d     = in_data;
            core_start_d  = 1'b1;
            core_in_vld_d = 1'b1;
            state_d       = S_START;
          end
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef HLS_INFER_INBUF_EN
    // Park a vector accepted while the core is busy, unless it was consumed above.
    if (in_fire && (state_q != S_IDLE) && !((state_q == S_OUT) && out_fire)) begin
      buf_data_d = in_data;
      buf_full_d = 1'b1;
    end
    in_ready_d = ~buf_full_d;
`else
    in_ready_d = (state_d == S_IDLE);
`endif
  end

  // State and output registers; async reset drops core_start immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      core_start_q  <= 1'b0;
      core_in_vld_q <= 1'b0;
      core_in_q     <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_err_q     <= 1'b0;
      got_vld_q     <= 1'b0;
      wait_cnt_q    <= '0;
      infer_count_q <= '0;
      timeout_cnt_q <= '0;
`ifdef HLS_INFER_INBUF_EN
      buf_full_q    <= 1'b0;
      buf_data_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      core_start_q  <= core_start_d;
      core_in_vld_q <= core_in_vld_d;
      core_in_q     <= core_in_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_err_q     <= out_err_d;
      got_vld_q     <= got_vld_d;
      wait_cnt_q    <= wait_cnt_d;
      infer_count_q <= infer_count_d;
      timeout_cnt_q <= timeout_cnt_d;
`ifdef HLS_INFER_INBUF_EN
      buf_full_q    <= buf_full_d;
      buf_data_q    <= buf_data_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_err     = out_err_q;
  assign core_start  = core_start_q;
  assign core_in     = core_in_q;
  assign core_in_vld = core_in_vld_q;
  assign infer_count = infer_count_q;
  assign timeout_cnt = timeout_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hls_infer_ctrl.sv
// Bench for hls_infer_ctrl (default build, no input buffer). A behavioural
// core is driven from the transaction task; the expected result of every
// transaction is decided up front from the core's scheduled behaviour
// (done honoured / timed out, result valid or not) and queued.
module tb_hls_infer_ctrl;

  localparam int N_IN     = 3;
  localparam int IN_W     = 16;
  localparam int N_OUT    = 1;
  localparam int OUT_W    = 16;
  localparam int TIMEOUT  = 16;
  localparam int CNT_W    = 32;
  localparam int IN_BITS  = N_IN * IN_W;
  localparam int OUT_BITS = N_OUT * OUT_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [IN_BITS-1:0]   in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_BITS-1:0]  out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_err;
  logic                 core_start;
  logic [IN_BITS-1:0]   core_in;
  logic                 core_in_vld;
  logic                 core_ready;
  logic                 core_done;
  logic [OUT_BITS-1:0]  core_out;
  logic                 core_out_vld;
  logic [CNT_W-1:0]     infer_count;
  logic [7:0]           timeout_cnt;
  logic [1:0]           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state
  logic [OUT_BITS-1:0] exp_q[$];
  logic                err_q[$];
  int                  exp_cnt = 0;
  int                  exp_to  = 0;

  hls_infer_ctrl #(
    .N_IN(N_IN), .IN_W(IN_W), .N_OUT(N_OUT), .OUT_W(OUT_W),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_err(out_err),
    .core_start(core_start), .core_in(core_in), .core_in_vld(core_in_vld),
    .core_ready(core_ready), .core_done(core_done), .core_out(core_out),
    .core_out_vld(core_out_vld),
    .infer_count(infer_count), .timeout_cnt(timeout_cnt),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_in_ready();
    int k = 0;
    while (in_ready !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    check("in_ready_avail", in_ready, 1);
  endtask

  // One full transaction. rdly: cycles core_ready stays low in START.
  // zl: done in the core_ready cycle. w: WAIT cycle index of done.
  // vmode: 0 no result vld, 1 vld with done, 2 vld early at WAIT cycle wearly.
  task automatic run_txn(input logic [IN_BITS-1:0] vec, input int rdly, input bit zl,
                         input int w, input int vmode, input int wearly,
                         input logic [OUT_BITS-1:0] res, input int stall);
    bit                  honoured, has_vld, done_seen;
    logic [OUT_BITS-1:0] ed;
    logic                ee;
    int                  wc;
    honoured = zl || (w < TIMEOUT);
    has_vld  = (vmode == 1) || (vmode == 2 && !zl && wearly < w);
    exp_q.push_back((honoured && has_vld) ? res : '0);
    err_q.push_back(!(honoured && has_vld));
    if (!honoured && exp_to < 255) exp_to++;

    wait_in_ready();
    in_data  = vec;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = IN_BITS'({$urandom, $urandom});
    check("start_latency", core_start, 1);
    check("core_in", core_in, vec);
    check("core_in_vld", core_in_vld, 1);
    check("in_ready_busy", in_ready, 0);

    for (int r = 0; r < rdly; r++) begin
      core_ready = 1'b0;
      tick();
      check("start_held", core_start, 1);
      check("core_in_stable", core_in, vec);
    end
    core_ready = 1'b1;
    if (zl) begin
      core_done    = 1'b1;
      core_out_vld = (vmode == 1);
      core_out     = (vmode == 1) ? res : OUT_BITS'($urandom);
    end
    tick();
    core_ready   = 1'b0;
    core_done    = 1'b0;
    core_out_vld = 1'b0;
    check("start_drop", core_start, 0);
    check("in_vld_drop", core_in_vld, 0);

    if (!zl) begin
      done_seen = 1'b0;
      wc = 0;
      while (!done_seen) begin
        check("wait_no_out", out_valid, 0);
        check("in_ready_wait", in_ready, 0);
        in_valid = 1'($urandom_range(0, 1));
        in_data  = IN_BITS'({$urandom, $urandom});
        core_out = OUT_BITS'($urandom);
        if (wc == w) core_done = 1'b1;
        if ((vmode == 1 && wc == w) || (vmode == 2 && wc == wearly)) begin
          core_out_vld = 1'b1;
          core_out     = res;
        end
        tick();
        core_done    = 1'b0;
        core_out_vld = 1'b0;
        in_valid     = 1'b0;
        if (wc == w || wc == TIMEOUT - 1) done_seen = 1'b1;
        wc++;
      end
    end

    ed = exp_q.pop_front();
    ee = err_q.pop_front();
    check("out_valid", out_valid, 1);
    check("out_data", out_data, ed);
    check("out_err", out_err, ee);
    check("timeout_cnt", timeout_cnt, exp_to);

    for (int s = 0; s < stall; s++) begin
      out_ready    = 1'b0;
      in_valid     = 1'($urandom_range(0, 1));
      in_data      = IN_BITS'({$urandom, $urandom});
      core_done    = 1'($urandom_range(0, 1));
      core_out_vld = 1'($urandom_range(0, 1));
      core_out     = OUT_BITS'($urandom);
      tick();
      in_valid     = 1'b0;
      core_done    = 1'b0;
      core_out_vld = 1'b0;
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, ed);
      check("stall_err", out_err, ee);
      check("stall_in_ready", in_ready, 0);
      check("stall_no_start", core_start, 0);
    end

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
    check("out_release", out_valid, 0);
    check("in_ready_ret", in_ready, 1);
    check("infer_count", infer_count, exp_cnt);
  endtask

  // Global time bound
  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout sim did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Stimulus
  initial begin
    int rdly, w, vmode, wearly, stall;
    bit zl;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    core_ready = 1'b0; core_done = 1'b0; core_out = '0; core_out_vld = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_out_data", out_data, 0);
    check("rst_core_in", core_in, 0);
    check("rst_infer_count", infer_count, 0);
    check("rst_timeout_cnt", timeout_cnt, 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);

    // Directed cases
    run_txn(48'h0003_0002_0001, 1, 0, 3, 1, 0, 16'h1234, 0);
    run_txn(48'hBEEF_CAFE_0042, 0, 0, 2, 1, 0, 16'h5A5A, 10);
    run_txn(48'h1111_2222_3333, 2, 0, TIMEOUT + 2, 1, 0, 16'h7777, 4);
    run_txn(48'h0000_0000_0009, 0, 0, 2, 0, 0, 16'hFFFF, 0);
    run_txn(48'h0102_0304_0506, 1, 1, 0, 1, 0, 16'h00C3, 1);
    run_txn(48'h0A0A_0B0B_0C0C, 0, 1, 0, 0, 0, 16'h9999, 0);
    run_txn(48'h7000_0600_0050, 0, 0, 5, 2, 1, 16'h4321, 2);
    run_txn(48'h0001_0001_0001, 0, 0, TIMEOUT - 1, 1, 0, 16'h0FF0, 0);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      zl    = ($urandom_range(0, 5) == 0);
      rdly  = $urandom_range(0, 3);
      w     = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 3)
                                          : $urandom_range(0, 8);
      vmode = $urandom_range(0, 2);
      wearly = (w > 0) ? $urandom_range(0, w - 1) : 0;
      if (vmode == 2 && (w == 0 || zl)) vmode = 0;
      stall = $urandom_range(0, 3);
      run_txn(IN_BITS'({$urandom, $urandom}), rdly, zl, w, vmode, wearly,
              OUT_BITS'($urandom), stall);
    end

    // Reset while core_start is high
    wait_in_ready();
    in_data  = 48'h0005_0006_0007;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pre_rst_start", core_start, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_start", core_start, 0);
    check("rst_mid_in_vld", core_in_vld, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_count", infer_count, 0);
    check("rst_mid_to", timeout_cnt, 0);
    check("rst_mid_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    exp_to  = 0;
    tick();
    run_txn(48'h0003_0002_0001, 0, 0, 1, 1, 0, 16'hABCD, 0);

    // Timeout counter saturation
    for (int i = 0; i < 258; i++) begin
      run_txn(IN_BITS'({$urandom, $urandom}), 0, 0, TIMEOUT + 1, 0, 0, '0, 0);
    end
    check("to_saturated", timeout_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
